regfile_write_bank: RTL and testbench
=====================================

// Module: regfile_write_bank
// PURPOSE
//  Write side of the register file. Its 32 registers drive the inputs of the 32:1 read-select mux.
//  - Accepts one write per cycle over a valid/ready handshake.
//  - Decodes a 5-bit select into 32 one-hot load enables (1:32 decode).
//  - Exposes all 32 registers as one flat bus.
//  - Provides a sequenced 32-cycle clear-all operation. Write-back from the datapath lands here.
// PARAMETERS
//  n        8   data width of each register
//  ZERO_R0  0   1 = register 0 reads as constant 0; writes to it are accepted and discarded
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  wr_valid    in   1      write request present
//  wr_ready    out  1      bank can accept a write this cycle
//  wr_sel      in   5      destination register index 0..31
//  wr_data     in   n      write data
//  clr_req     in   1      request clear-all (sampled only in IDLE)
//  clr_busy    out  1      clear sequence in progress
//  last_write  out  32     registered one-hot of the register written in the previous cycle
//  regs_flat   out  32*n   register k at bits [k*n +: n]
// BEHAVIOUR
//  Reset (rst=1 at an edge): all registers 0, state IDLE, clear counter 0, last_write 0, clr_busy 0.
//   wr_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
//  States: IDLE, CLEAR.
//  IDLE:
//   - wr_ready=1. Write fires when wr_valid && wr_ready at an edge.
//   - The fired edge loads reg[wr_sel]. The new value appears on regs_flat the next cycle (1-cycle latency).
//   - last_write = onehot(wr_sel) for exactly one cycle after the fired edge. Otherwise last_write=0.
//   - ZERO_R0=1 and wr_sel=0: data is discarded, last_write stays 0, and the handshake still completes.
//   - Back-to-back writes to the same index: the last one wins. No stall.
//   - clr_req=1: go to CLEAR at the next edge with counter=0.
//   - wr_valid and clr_req in the same cycle: the write commits on that edge, CLEAR starts the next cycle.
//     The clear later zeroes that register.
//  CLEAR:
//   - wr_ready=0, clr_busy=1.
//   - Each cycle zeroes reg[counter] and increments counter (5-bit).
//   - At counter=31 that register is zeroed, counter wraps to 0 and state returns to IDLE.
//     Exactly 32 busy cycles.
//   - clr_req and wr_valid are ignored in CLEAR. A write held with wr_valid=1 is accepted in the first IDLE cycle.
//   - last_write is 0 throughout.
//  Reset mid-CLEAR: aborts at once to IDLE. All registers are 0 from the reset, so the clear result still holds.
//  regs_flat is a direct register view with no combinational path from the wr_* inputs.
// STRUCTURE
//  Shared package regfile_pkg: NUM_REGS=32, SEL_W=5, state encoding (IDLE=1'b0, CLEAR=1'b1).
//   The read-side mux uses the same NUM_REGS/SEL_W constants.
//  Sub-module decoder_5to32: en, sel[4:0] -> onehot[31:0]. Output is 0 when en=0.
//   Driven with en = write fire (IDLE) or 1 (CLEAR), and sel = wr_sel or counter.
//  Top level: FSM + counter, 32 n-bit registers with per-register load enable and a data mux (wr_data vs 0).
// TESTING
//  1. Reset, then write sel=5'h0A data=8'hA5 -> regs_flat[80+:8]=8'hA5 one cycle later.
//     last_write=32'h0000_0400 for one cycle. All other registers still 0.
//  2. Write all 32 indices in consecutive cycles with data=index+1 -> wr_ready stays 1 and every register holds index+1.
//     Feed the read mux and check all 32 selects.
//  3. Fill the registers, pulse clr_req -> clr_busy=1 for exactly 32 cycles and reg k reads 0 from cycle k+1.
//     wr_valid held high during the clear is not accepted until the first IDLE cycle.
//  4. Assert wr_valid (sel=3, data=8'h3C) together with clr_req -> reg3=8'h3C for 4 cycles, then 0 once the sweep passes it.
//     No write is lost in the handshake.
//  5. With ZERO_R0=1, write sel=0 data=8'hFF -> reg0 stays 0, last_write=0, and the handshake completes in one cycle.
//  6. Assert rst at clear cycle 10 -> next cycle state is IDLE, clr_busy=0, all registers 0, and wr_ready=1 after rst drops.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register file (write bank and read mux).
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SEL_W    = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_bank_decoder.sv
// 1:32 one-hot decoder with enable.
// Ports: en (decode enable), sel (register index), onehot (one-hot load enables, all 0 when en=0).
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);

    assign onehot = en ? (NUM_REGS'(1) << sel) : '0;

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the register file: handshaked single writes, sequenced 32-cycle clear-all,
// flat view of all registers for the read mux.
// Ports: clk, rst (sync, active-high); wr_valid/wr_ready/wr_sel/wr_data write channel;
//        clr_req/clr_busy clear-all control; last_write one-hot of previous cycle's write;
//        regs_flat register k at [k*n +: n].
module regfile_write_bank
    import regfile_pkg::*;
#(
    parameter int unsigned n       = 8,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [n-1:0]          wr_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic [NUM_REGS-1:0]   last_write,
    output logic [NUM_REGS*n-1:0] regs_flat
);

    state_t                state;
    state_t                state_next;
    logic [SEL_W-1:0]      cnt;
    logic [SEL_W-1:0]      cnt_next;
    logic                  fire;
    logic                  dec_en;
    logic [SEL_W-1:0]      dec_sel;
    logic [NUM_REGS-1:0]   dec_out;
    logic [NUM_REGS-1:0]   load_en;
    logic [NUM_REGS-1:0]   lw_next;
    logic [n-1:0]          load_data;
    logic [n-1:0]          regs_q [NUM_REGS];

    // Ready is gated by rst so no write can fire on a reset edge.
    assign wr_ready = (state == IDLE) && !rst;
    assign fire     = wr_valid && wr_ready;
    assign clr_busy = (state == CLEAR);

    // Next state, counter and decoder steering.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dec_en     = fire;
        dec_sel    = wr_sel;
        load_data  = wr_data;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                dec_en    = 1'b1;
                dec_sel   = cnt;
                load_data = '0;
                cnt_next  = cnt + SEL_W'(1);
                if (cnt == SEL_W'(NUM_REGS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    decoder_5to32 u_dec (
        .en     (dec_en),
        .sel    (dec_sel),
        .onehot (dec_out)
    );

    // Hardwired-zero r0 swallows writes but the sweep still clears it.
    always_comb begin
        load_en = dec_out;
        if (ZERO_R0 && (state == IDLE)) begin
            load_en[0] = 1'b0;
        end
        lw_next = (state == IDLE) ? load_en : '0;
    end

    // State, counter and write indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_write <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_write <= lw_next;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rst) begin
                regs_q[k] <= '0;
            end else if (load_en[k]) begin
                regs_q[k] <= load_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*n +: n] = regs_q[g];
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
module tb_regfile_write_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic [4:0]   wr_sel;
    logic [7:0]   wr_data;
    logic         clr_req;

    logic         wr_ready0, wr_ready1;
    logic         clr_busy0, clr_busy1;
    logic [31:0]  last_write0, last_write1;
    logic [255:0] flat0, flat1;

    int tests = 0;
    int fails = 0;

    // Reference model, one per instance (index 0: ZERO_R0=0, index 1: ZERO_R0=1).
    logic [7:0]  m   [2][32];
    bit          mb  [2];
    int          mc  [2];
    logic [31:0] mlw [2];

    always #5 clk = ~clk;

    regfile_write_bank #(.n(8), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy0),
        .last_write(last_write0), .regs_flat(flat0)
    );

    regfile_write_bank #(.n(8), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy1),
        .last_write(last_write1), .regs_flat(flat1)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the edge about to happen must do, from the behavioural rules.
    task automatic model_update(input int i);
        if (rst) begin
            for (int k = 0; k < 32; k++) m[i][k] = 8'h00;
            mb[i] = 0; mc[i] = 0; mlw[i] = 32'h0;
        end else if (!mb[i]) begin
            mlw[i] = 32'h0;
            if (wr_valid) begin
                if (!(i == 1 && wr_sel == 5'd0)) begin
                    m[i][wr_sel] = wr_data;
                    mlw[i] = 32'h1 << wr_sel;
                end
            end
            if (clr_req) begin
                mb[i] = 1; mc[i] = 0;
            end
        end else begin
            m[i][mc[i]] = 8'h00;
            mlw[i] = 32'h0;
            if (mc[i] == 31) begin
                mb[i] = 0; mc[i] = 0;
            end else begin
                mc[i]++;
            end
        end
    endtask

    task automatic compare_all();
        logic [255:0] ef;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 32; k++) ef[k*8 +: 8] = m[i][k];
            check($sformatf("regs_flat%0d", i), (i == 0) ? flat0 : flat1, ef);
            check($sformatf("last_write%0d", i), 256'((i == 0) ? last_write0 : last_write1), 256'(mlw[i]));
            check($sformatf("clr_busy%0d", i), 256'((i == 0) ? clr_busy0 : clr_busy1), 256'(mb[i]));
            check($sformatf("wr_ready%0d", i), 256'((i == 0) ? wr_ready0 : wr_ready1),
                  256'(!mb[i] && !rst));
        end
    endtask

    task automatic step();
        model_update(0);
        model_update(1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain_clear();
        for (int t = 0; t < 40 && clr_busy0; t++) step();
        check("drain_clear_timeout", 256'(clr_busy0), 256'(0));
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1: single write
        wr_valid = 1'b1; wr_sel = 5'h0A; wr_data = 8'hA5;
        step();
        wr_valid = 1'b0;
        check("t1_reg10", 256'(flat0[80 +: 8]), 256'(8'hA5));
        check("t1_lw", 256'(last_write0), 256'(32'h0000_0400));
        check("t1_others", flat0 & ~(256'hFF << 80), 256'h0);
        step();
        check("t1_lw_gone", 256'(last_write0), 256'h0);

        // 2: write all indices back-to-back, then read each select
        for (int k = 0; k < 32; k++) begin
            wr_valid = 1'b1; wr_sel = 5'(k); wr_data = 8'(k + 1);
            check("t2_ready", 256'(wr_ready0), 256'(1));
            step();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("t2_mux%0d", k), 256'(flat0[k*8 +: 8]), 256'(8'(k + 1)));
        end

        // 3: clear with a write held pending; write coincides with clr_req
        wr_valid = 1'b1; wr_sel = 5'd7; wr_data = 8'h77; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int t = 0; t < 40 && clr_busy0; t++) begin
            busy_cnt++;
            step();
        end
        check("t3_busy_cycles", 256'(busy_cnt), 256'(32));
        check("t3_all_zero", flat0, 256'h0);
        step();
        wr_valid = 1'b0;
        check("t3_held_write", 256'(flat0[56 +: 8]), 256'(8'h77));
        check("t3_held_lw", 256'(last_write0), 256'(32'h80));

        // 4: write together with clr_req
        wr_valid = 1'b1; wr_sel = 5'd3; wr_data = 8'h3C; clr_req = 1'b1;
        step();
        wr_valid = 1'b0; clr_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t4_reg3_c%0d", j), 256'(flat0[24 +: 8]), 256'(8'h3C));
            step();
        end
        check("t4_reg3_cleared", 256'(flat0[24 +: 8]), 256'(8'h00));
        drain_clear();

        // 5: ZERO_R0 instance discards r0 writes
        wr_valid = 1'b1; wr_sel = 5'd0; wr_data = 8'hFF;
        check("t5_ready", 256'(wr_ready1), 256'(1));
        step();
        wr_valid = 1'b0;
        check("t5_r0", 256'(flat1[7:0]), 256'(8'h00));
        check("t5_lw", 256'(last_write1), 256'h0);
        check("t5_r0_plain", 256'(flat0[7:0]), 256'(8'hFF));

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_sel   = 5'($urandom_range(0, 31));
            wr_data  = 8'($urandom);
            clr_req  = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0; clr_req = 1'b0; wr_valid = 1'b0;
        step();
        drain_clear();
        for (int k = 0; k < 32; k++) begin
            wr_valid = 1'b1; wr_sel = 5'(k); wr_data = 8'($urandom_range(1, 255));
            step();
        end
        wr_valid = 1'b0;

        // 6: reset during clear cycle 10
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int j = 0; j < 9; j++) step();
        rst = 1'b1;
        wr_valid = 1'b1;
        step();
        check("t6_busy", 256'(clr_busy0), 256'(0));
        check("t6_zero", flat0, 256'h0);
        check("t6_ready_in_rst", 256'(wr_ready0), 256'(0));
        rst = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("t6_ready_after", 256'(wr_ready0), 256'(1));
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
